// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, signs applied in a final fix-up cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: low half holds dividend/quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               is_div_q, is_div_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   raw_a;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};

  // Partial remainder is WIDTH+1 bits only transiently; the kept remainder is always < divisor.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;

  assign res_neg  = neg_a_q ^ neg_b_q;
  assign prod_fix = res_neg ? -acc_q : acc_q;
  assign quo_fix  = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -rem_q : rem_q;
  // Re-negating the magnitude recovers the raw operand bit-exactly, MIN included.
  assign raw_a    = neg_a_q ? -mag_a_q : mag_a_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    is_div_d   = is_div_q;
    b_zero_d   = b_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      StIdle: begin
        if (mt_hi) hi_d = mt_data;
        if (mt_lo) lo_d = mt_data;
        if (start && !flush) begin
          mag_a_d    = a_mag;
          mag_b_d    = b_mag;
          neg_a_d    = a_neg;
          neg_b_d    = b_neg;
          is_div_d   = op[1];
          b_zero_d   = (b == '0);
          div_zero_d = 1'b0;
          cnt_d      = CNT_W'(WIDTH);
          rem_d      = '0;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          state_d    = op[1] ? StDiv : StMul;
        end
      end

      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = StFix;
        end
      end

      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          rem_d                = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_d[WIDTH-1:0]     = {acc_q[WIDTH-2:0], div_ge};
          cnt_d                = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = StFix;
        end
      end

      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (b_zero_q) begin
            hi_d       = raw_a;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      is_div_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      is_div_q   <= is_div_d;
      b_zero_q   <= b_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances share stimulus and are checked every
// cycle against an arithmetic reference model, plus directed literal expectations.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, flush, mt_hi, mt_lo;
  logic [1:0]  op;
  logic [31:0] a, b, mt_data;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]), .flush(flush),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data[7:0]),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 is the 32-bit unit, index 1 the 8-bit unit.
  bit          m_busy[2], m_done[2], m_dz[2], p_dz[2];
  logic [31:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
  int          m_cnt[2];

  function automatic void compute(input int w, input logic [1:0] op_i, input logic [31:0] a_i,
                                  input logic [31:0] b_i, output logic [31:0] rh,
                                  output logic [31:0] rl, output bit dz);
    longint unsigned mask, ua, ub, up;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, a_i} & mask;
    ub = {32'b0, b_i} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - longint'(64'd1 << w);
    if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - longint'(64'd1 << w);
    dz = 1'b0;
    case (op_i)
      2'b00: up = sa * sb;
      2'b01: up = ua * ub;
      default: begin
        if (ub == 0) begin
          up = (ua << w) | mask;
          dz = 1'b1;
        end else begin
          if (op_i == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
          end
          up = ((r & mask) << w) | (q & mask);
        end
      end
    endcase
    rh = 32'((up >> w) & mask);
    rl = 32'(up & mask);
  endfunction

  task automatic model_step(input int k, input int w);
    logic [31:0] mask, th, tl;
    bit td;
    mask = 32'((64'd1 << w) - 64'd1);
    m_done[k] = 1'b0;
    if (rst) begin
      m_busy[k] = 1'b0; m_dz[k] = 1'b0; m_hi[k] = '0; m_lo[k] = '0; m_cnt[k] = 0;
    end else if (m_busy[k]) begin
      if (flush) begin
        m_busy[k] = 1'b0;
      end else begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
          m_hi[k]   = p_hi[k];
          m_lo[k]   = p_lo[k];
          m_dz[k]   = p_dz[k];
        end
      end
    end else begin
      if (mt_hi) m_hi[k] = mt_data & mask;
      if (mt_lo) m_lo[k] = mt_data & mask;
      if (start && !flush) begin
        m_busy[k] = 1'b1;
        m_cnt[k]  = w + 1;
        m_dz[k]   = 1'b0;
        compute(w, op, a, b, th, tl, td);
        p_hi[k] = th; p_lo[k] = tl; p_dz[k] = td;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 32);
    model_step(1, 8);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy32", {31'b0, busy32}, {31'b0, m_busy[0]});
      chk("done32", {31'b0, done32}, {31'b0, m_done[0]});
      chk("dz32",   {31'b0, dz32},   {31'b0, m_dz[0]});
      chk("hi32",   hi32,            m_hi[0]);
      chk("lo32",   lo32,            m_lo[0]);
      chk("busy8",  {31'b0, busy8},  {31'b0, m_busy[1]});
      chk("done8",  {31'b0, done8},  {31'b0, m_done[1]});
      chk("dz8",    {31'b0, dz8},    {31'b0, m_dz[1]});
      chk("hi8",    {24'b0, hi8},    m_hi[1]);
      chk("lo8",    {24'b0, lo8},    m_lo[1]);
    end
  end

  // Issues one op from a negedge; returns at the negedge of the cycle after the start edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles (start-edge cycle = 1) until each unit's done; stops on the 32-bit done.
  task automatic wait_done(output int n32, output int n8);
    n32 = 0; n8 = 0;
    for (int i = 1; i <= 80; i++) begin
      if (done8 && n8 == 0) n8 = i;
      if (done32) begin
        n32 = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y);
    int n32, n8;
    issue(o, x, y);
    wait_done(n32, n8);
    chk({tag, "_lat32"}, n32, 34);
    chk({tag, "_lat8"},  n8,  10);
  endtask

  initial begin
    logic [31:0] lo_before;
    bit seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; mt_data = '0;
    @(posedge clk);
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_hi",   hi32, 32'd0);
    chk("rst_lo",   {24'b0, lo8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi", hi32, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo32, 32'h0000_0001);
    chk("multu_max_hi8", {24'b0, hi8}, 32'hFE);
    chk("multu_max_lo8", {24'b0, lo8}, 32'h01);

    run("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg_hi", hi32, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo32, 32'hFFFF_FFF1);
    chk("mult_neg_lo8", {24'b0, lo8}, 32'hF1);

    run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo", lo32, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi32, 32'hFFFF_FFFF);
    chk("div_neg_lo8", {24'b0, lo8}, 32'hFD);

    run("divu_zero", 2'b11, 32'h0000_1234, 32'd0);
    chk("divu_zero_lo", lo32, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi32, 32'h0000_1234);
    chk("divu_zero_dz", {31'b0, dz32}, 32'd1);
    chk("divu_zero_hi8", {24'b0, hi8}, 32'h34);
    chk("divu_zero_dz8", {31'b0, dz8}, 32'd1);

    begin
      int n32, n8;
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("dz_clear32", {31'b0, dz32}, 32'd0);
      chk("dz_clear8",  {31'b0, dz8},  32'd0);
      wait_done(n32, n8);
      chk("ovf_lat32", n32, 34);
    end
    chk("ovf_lo", lo32, 32'h8000_0000);
    chk("ovf_hi", hi32, 32'h0000_0000);
    chk("ovf_dz", {31'b0, dz32}, 32'd0);

    run("div8", 2'b10, 32'h0000_0085, 32'h0000_000A);
    chk("div8_lo8", {24'b0, lo8}, 32'hF4);
    chk("div8_hi8", {24'b0, hi8}, 32'hFD);
    chk("div8_lo32", lo32, 32'h0000_000D);
    chk("div8_hi32", hi32, 32'h0000_0003);

    // MTHI in idle, then an op that is flushed mid-flight with an ignored start pulse.
    mt_hi = 1'b1; mt_data = 32'hAAAA_0000;
    @(negedge clk);
    mt_hi = 1'b0;
    lo_before = lo32;
    chk("mthi_hi", hi32, 32'hAAAA_0000);
    issue(2'b01, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy32}, 32'd0);
    chk("flush_hi", hi32, 32'hAAAA_0000);
    chk("flush_lo", lo32, lo_before);
    seen = 1'b0;
    repeat (40) begin
      if (done32) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_nodone", {31'b0, seen}, 32'd0);

    issue(2'b10, 32'h0000_0085, 32'h0000_000A);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy8", {31'b0, busy8}, 32'd0);
    chk("rst_mid_hi8", {24'b0, hi8}, 32'd0);
    chk("rst_mid_lo8", {24'b0, lo8}, 32'd0);
    chk("rst_mid_busy32", {31'b0, busy32}, 32'd0);
    chk("rst_mid_lo32", lo32, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 4) == 0;
      op    = 2'($urandom % 4);
      case ($urandom % 6)
        0:       a = 32'h8000_0000;
        1:       a = 32'h0000_0080;
        2:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom % 6)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      flush   = ($urandom % 40) == 0;
      mt_hi   = ($urandom % 10) == 0;
      mt_lo   = ($urandom % 10) == 0;
      mt_data = $urandom;
      rst     = ($urandom % 400) == 0;
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU. It holds `busy` high so the hazard unit stalls any HI/LO consumer until the result lands. It also services MTHI/MTLO writes and supports a flush from branch/exception recovery.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (legal range ≥ 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  abort the in-flight operation
mt_hi  input  1  MTHI write strobe
mt_lo  input  1  MTLO write strobe
mt_data  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in flight; hazard unit stalls MFHI/MFLO/muldiv issue
done  output  1  one-cycle pulse: HI/LO updated by a completed op
div_zero  output  1  sticky-until-next-start flag: last divide had b == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: busy=0, done=0, div_zero=0, hi=0, lo=0, FSM=IDLE, counter=0. Reset mid-operation aborts the operation; HI/LO are cleared.
- FSM states are IDLE, MUL, DIV, FIX.
- IDLE:
  - On start at edge E0: latch |a| and |b|, taking magnitudes only for signed ops and treating them as unsigned WIDTH-bit values. Latch the result sign rules. Clear div_zero. Load counter=WIDTH.
  - Then go to MUL (op[1]=0) or DIV (op[1]=1). busy=1 from E0 onward.
- MUL: shift-add, one multiplier bit per cycle, over a 2*WIDTH-bit accumulator. Counter decrements each edge; leave for FIX when the counter reaches 0 (edges E1..E_WIDTH).
- DIV: restoring division, one quotient bit per cycle, over a WIDTH+1-bit partial remainder. Same counter rule.
- FIX (edge E_WIDTH+1):
  - Apply signs. Product is negated if sign(a)^sign(b). Quotient is negated if sign(a)^sign(b). Remainder takes the sign of a.
  - Write {hi,lo} = product for multiply; lo=quotient, hi=remainder for divide.
  - done=1 for exactly the cycle after E_WIDTH+1. busy=0 in that same cycle. Return to IDLE.
- Latency: results are visible WIDTH+2 cycles after the start edge; back-to-back start is allowed in the done cycle.
- Divide by zero: no iteration shortcut; timing is unchanged. Result is lo={WIDTH{1}}, hi=a (raw operand), div_zero=1.
- Signed overflow DIV MIN/−1: lo=MIN, hi=0. No flag.
- start while busy: ignored, with no queueing. A stalled pipeline must not assert it.
- flush:
  - Any non-IDLE state goes to IDLE next edge. busy=0, no done, HI/LO keep their pre-op values.
  - flush with start in the same IDLE cycle: flush wins, op not started.
  - flush in the FIX cycle: flush wins, no write.
- mt_hi/mt_lo:
  - In IDLE they write the register next edge, and may coincide with start; the op result later overwrites.
  - While busy they are ignored.
  - mt_hi and mt_lo together write both registers.
- done is never asserted by MT writes.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy for 33 cycles; done in cycle 34 after start edge; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, div_zero=1. Next start clears div_zero.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- mt_hi=0xAAAA0000 in IDLE, then start MULTU 6×7, then flush at cycle 10 → busy drops next cycle, no done, hi=0xAAAA0000, lo unchanged. A start pulse mid-op is ignored.
- WIDTH=8 instance: DIV a=0x85 (−123), b=0x0A → lo=0xF4 (−12), hi=0xFD (−3), done 10 cycles after start. Assert rst mid-DIV → all outputs 0 next edge.
